wave_capture_ctrl: RTL and testbench

Capture and display sequencer for the waveform display path.
- Watches the incoming 10-bit voice sample stream and waits for a rising crossing of a trigger level.
- Writes exactly one 1280-sample frame into the display sample memory, then holds the frame stable for a fixed time.
- Owns the display-mode selector (off / normal / circle / bar) and a freeze toggle.
- Sits between the mic sampler and the waveform-drawing block. It replaces free-running circular writes with triggered, tear-free frames.

---
 rtl/wave_capture_ctrl.sv | 160 ++++++++++++++++
 tb/tb_wave_capture_ctrl.sv | 205 ++++++++++++++++++++
 2 files changed

// File: rtl/wave_capture_ctrl.sv
// rtl/wave_capture_ctrl.sv - triggered tear-free frame capture, display mode and freeze control.
// Optional auto-trigger on WAIT_TRIG timeout is enabled by defining WAVE_AUTOTRIG_EN.
module wave_capture_ctrl #(
    parameter int DEPTH         = 1280,
    parameter int AW            = 11,
    parameter int DW            = 10,
    parameter int HOLD_TICKS    = 2000,
    parameter int TIMEOUT_TICKS = 4000
) (
    input  logic          CLK_VGA,
    input  logic          rst_n,
    input  logic          sample_tick,
    input  logic [DW-1:0] wave_sample,
    input  logic [DW-1:0] trig_level,
    input  logic          mode_btn,
    input  logic          freeze_btn,
    output logic          wr_en,
    output logic [AW-1:0] wr_addr,
    output logic [DW-1:0] wr_data,
    output logic [1:0]    Waveform_State,
    output logic          frozen,
    output logic          frame_done,
    output logic          auto_trig
);

    localparam int HW = (HOLD_TICKS > 1) ? $clog2(HOLD_TICKS) : 1;
    localparam logic [HW-1:0] HOLD_LAST  = HW'(HOLD_TICKS - 1);
    localparam logic [AW-1:0] DEPTH_LAST = AW'(DEPTH - 1);

    generate
        if (TIMEOUT_TICKS < 1 || (64'd1 << AW) < 64'(DEPTH) || HOLD_TICKS < 1) begin : g_bad_cfg
            $error("wave_capture_ctrl: invalid parameter set");
        end
    endgenerate

    typedef enum logic [1:0] {IDLE, WAIT_TRIG, CAPTURE, HOLD} state_t;

    state_t          state;
    logic [DW-1:0]   prev_sample;
    logic            prev_valid;
    logic [AW-1:0]   addr;
    logic [HW-1:0]   hold_cnt;
    logic            trig;

`ifdef WAVE_AUTOTRIG_EN
    localparam int TW = (TIMEOUT_TICKS > 1) ? $clog2(TIMEOUT_TICKS) : 1;
    localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT_TICKS - 1);
    logic [TW-1:0]   tmo_cnt;
`else
    assign auto_trig = 1'b0;
`endif

    // prev_valid blocks a stale pre-arm sample from forming a false crossing
    assign trig = sample_tick & prev_valid & (prev_sample < trig_level) & (wave_sample >= trig_level);

    always_ff @(posedge CLK_VGA or negedge rst_n) begin
        if (!rst_n) begin
            state          <= IDLE;
            wr_en          <= 1'b0;
            wr_addr        <= '0;
            wr_data        <= '0;
            Waveform_State <= 2'b01;
            frozen         <= 1'b0;
            frame_done     <= 1'b0;
            prev_sample    <= '0;
            prev_valid     <= 1'b0;
            addr           <= '0;
            hold_cnt       <= '0;
`ifdef WAVE_AUTOTRIG_EN
            auto_trig      <= 1'b0;
            tmo_cnt        <= '0;
`endif
        end else begin
            wr_en      <= 1'b0;
            frame_done <= 1'b0;
            if (mode_btn)
                Waveform_State <= Waveform_State + 2'd1;
            if (freeze_btn)
                frozen <= ~frozen;
            if (sample_tick)
                prev_sample <= wave_sample;

            case (state)
                IDLE: begin
                    if (!frozen) begin
                        state      <= WAIT_TRIG;
                        prev_valid <= 1'b0;
`ifdef WAVE_AUTOTRIG_EN
                        tmo_cnt    <= '0;
`endif
                    end
                end
                WAIT_TRIG: begin
                    if (frozen) begin
                        state <= IDLE;
                    end else if (trig) begin
                        wr_en   <= 1'b1;
                        wr_addr <= '0;
                        wr_data <= wave_sample;
                        addr    <= AW'(1);
                        state   <= CAPTURE;
`ifdef WAVE_AUTOTRIG_EN
                        auto_trig <= 1'b0;
                    end else if (sample_tick && tmo_cnt == TMO_LAST) begin
                        wr_en     <= 1'b1;
                        wr_addr   <= '0;
                        wr_data   <= wave_sample;
                        addr      <= AW'(1);
                        state     <= CAPTURE;
                        auto_trig <= 1'b1;
                    end else if (sample_tick) begin
                        prev_valid <= 1'b1;
                        tmo_cnt    <= tmo_cnt + 1'b1;
                    end
`else
                    end else if (sample_tick) begin
                        prev_valid <= 1'b1;
                    end
`endif
                end
                CAPTURE: begin
                    // freeze is deliberately ignored here so a frame is never torn
                    if (sample_tick) begin
                        wr_en   <= 1'b1;
                        wr_addr <= addr;
                        wr_data <= wave_sample;
                        if (addr == DEPTH_LAST) begin
                            frame_done <= 1'b1;
                            addr       <= '0;
                            hold_cnt   <= '0;
                            state      <= HOLD;
                        end else begin
                            addr <= addr + 1'b1;
                        end
                    end
                end
                HOLD: begin
                    if (sample_tick) begin
                        if (hold_cnt == HOLD_LAST) begin
                            hold_cnt <= '0;
                            if (frozen) begin
                                state <= IDLE;
                            end else begin
                                state      <= WAIT_TRIG;
                                prev_valid <= 1'b0;
`ifdef WAVE_AUTOTRIG_EN
                                tmo_cnt    <= '0;
`endif
                            end
                        end else begin
                            hold_cnt <= hold_cnt + 1'b1;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_wave_capture_ctrl.sv
// tb/tb_wave_capture_ctrl.sv - scoreboard bench for wave_capture_ctrl.
module tb_wave_capture_ctrl;

    localparam int DEPTH = 1280;
    localparam int AW    = 11;
    localparam int DW    = 10;
    localparam int HOLD  = 2000;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          sample_tick = 1'b0;
    logic [DW-1:0] wave_sample = '0;
    logic [DW-1:0] trig_level = 10'd512;
    logic          mode_btn = 1'b0;
    logic          freeze_btn = 1'b0;
    logic          wr_en;
    logic [AW-1:0] wr_addr;
    logic [DW-1:0] wr_data;
    logic [1:0]    Waveform_State;
    logic          frozen;
    logic          frame_done;
    logic          auto_trig;

    int total = 0;
    int bad = 0;
    int fd_count = 0;
    logic [AW+DW-1:0] exp_q[$];

    always #5 clk = ~clk;

    wave_capture_ctrl #(
        .DEPTH(DEPTH), .AW(AW), .DW(DW), .HOLD_TICKS(HOLD), .TIMEOUT_TICKS(8)
    ) dut (
        .CLK_VGA(clk), .rst_n(rst_n), .sample_tick(sample_tick),
        .wave_sample(wave_sample), .trig_level(trig_level),
        .mode_btn(mode_btn), .freeze_btn(freeze_btn),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .Waveform_State(Waveform_State), .frozen(frozen),
        .frame_done(frame_done), .auto_trig(auto_trig)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    always @(negedge clk) begin
        if (wr_en === 1'b1) begin
            logic [AW+DW-1:0] e;
            check("wr_pending", 32'(exp_q.size() > 0), 1);
            check("wr_addr_range", 32'(wr_addr <= AW'(DEPTH - 1)), 1);
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                check("wr_addr", 32'(wr_addr), 32'(e[AW+DW-1:DW]));
                check("wr_data", 32'(wr_data), 32'(e[DW-1:0]));
            end
        end
        if (frame_done === 1'b1) begin
            fd_count++;
            check("fd_on_last_wr", 32'(wr_en && wr_addr == AW'(DEPTH - 1)), 1);
        end
    end

    task automatic do_tick(input logic [DW-1:0] s, input bit wr, input int a,
                           input bit m = 1'b0, input bit f = 1'b0);
        logic [AW-1:0] aa;
        aa = a[AW-1:0];
        if (wr) exp_q.push_back({aa, s});
        @(posedge clk); #1;
        sample_tick = 1'b1; wave_sample = s; mode_btn = m; freeze_btn = f;
        @(posedge clk); #1;
        sample_tick = 1'b0; mode_btn = 1'b0; freeze_btn = 1'b0;
    endtask

    function automatic logic [DW-1:0] pat(input int i);
        pat = DW'((i * 37 + 5) % 1024);
    endfunction

    task automatic capture_rest(input int freeze_at);
        for (int i = 1; i < DEPTH; i++) begin
            do_tick(pat(i), 1'b1, i, 1'b0, i == freeze_at);
            if (i == freeze_at) check("frozen_mid_capture", 32'(frozen), 1);
        end
        @(negedge clk); #1;
    endtask

    task automatic hold_ticks();
        for (int i = 1; i <= HOLD; i++)
            do_tick((i % 2 == 1) ? 10'd400 : 10'd600, 1'b0, 0);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_wr_en"}, 32'(wr_en), 0);
        check({tag, "_wr_addr"}, 32'(wr_addr), 0);
        check({tag, "_wr_data"}, 32'(wr_data), 0);
        check({tag, "_mode"}, 32'(Waveform_State), 1);
        check({tag, "_frozen"}, 32'(frozen), 0);
        check({tag, "_frame_done"}, 32'(frame_done), 0);
        check({tag, "_auto_trig"}, 32'(auto_trig), 0);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: got=timeout exp=finish");
        $fatal(1);
    end

    initial begin
        logic [1:0] modes[4];
        int k;
        modes[0] = 2'b10; modes[1] = 2'b11; modes[2] = 2'b00; modes[3] = 2'b01;

        repeat (3) @(posedge clk);
        #1;
        check_reset_outputs("reset");
        rst_n = 1'b1;
        repeat (3) @(posedge clk);
        #1;

        // first WAIT_TRIG tick must not trigger on a stale prev_sample
        do_tick(10'd600, 1'b0, 0);
        do_tick(10'd500, 1'b0, 0);
        do_tick(10'd600, 1'b1, 0);
        capture_rest(-1);
        check("fd_count_f1", 32'(fd_count), 1);

        // hold boundary: early exit would trigger on the 400->600 pair below
        hold_ticks();
        do_tick(10'd600, 1'b0, 0);
        do_tick(10'd400, 1'b0, 0);
        do_tick(10'd600, 1'b1, 0);
        capture_rest(300);
        check("fd_count_f2", 32'(fd_count), 2);
        check("frozen_after_f2", 32'(frozen), 1);

        hold_ticks();
        for (int i = 0; i < 10; i++)
            do_tick((i % 2 == 0) ? 10'd400 : 10'd600, 1'b0, 0);
        check("frozen_idle", 32'(frozen), 1);

        @(posedge clk); #1;
        freeze_btn = 1'b1;
        @(posedge clk); #1;
        freeze_btn = 1'b0;
        check("unfrozen", 32'(frozen), 0);
        repeat (3) @(posedge clk);
        #1;
        do_tick(10'd400, 1'b0, 0);
        do_tick(10'd600, 1'b1, 0);

        k = 0;
        for (int i = 1; i < DEPTH; i++) begin
            bit m;
            bit f;
            m = (i == 100 || i == 200 || i == 300 || i == 400 || i == 500);
            f = (i == 500);
            do_tick(pat(i), 1'b1, i, m, f);
            if (i == 500) begin
                check("mode_with_freeze", 32'(Waveform_State), 32'(2'b10));
                check("freeze_with_mode", 32'(frozen), 1);
            end else if (m) begin
                check("mode_cycle", 32'(Waveform_State), 32'(modes[k]));
                k++;
            end
        end
        @(negedge clk); #1;
        check("fd_count_f3", 32'(fd_count), 3);

        rst_n = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        repeat (3) @(posedge clk);
        #1;
`ifdef WAVE_AUTOTRIG_EN
        for (int i = 1; i <= 8; i++)
            do_tick(10'd100, i == 8, 0);
        check("auto_trig_set", 32'(auto_trig), 1);
`else
        do_tick(10'd400, 1'b0, 0);
        do_tick(10'd600, 1'b1, 0);
        check("auto_trig_off", 32'(auto_trig), 0);
`endif
        for (int a = 1; a <= 50; a++)
            do_tick(10'd100, 1'b1, a);
        @(negedge clk); #1;
        check("queue_before_reset", 32'(exp_q.size()), 0);
        rst_n = 1'b0;
        #1;
        check_reset_outputs("mid_reset");
        @(posedge clk); #1;
        rst_n = 1'b1;
        for (int i = 0; i < 5; i++)
            do_tick(10'd100, 1'b0, 0);
        @(negedge clk); #1;
        check("queue_final", 32'(exp_q.size()), 0);
        check("fd_count_final", 32'(fd_count), 3);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
